// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: register addresses, source
// bit positions, vector base and FSM encodings.
package interrupt_controller_pkg;
  localparam int NUM_SRC = 5;

  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [7:0] VEC_BASE = 8'h40;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef logic [NUM_SRC-1:0] irq_vec_t;

  // Vectors are spaced 8 bytes apart starting at the base.
  function automatic logic [7:0] irq_vector_of(input logic [7:0] base, input logic [2:0] idx);
    return base + {2'b00, idx, 3'b000};
  endfunction
endpackage

// File: rtl/interrupt_controller_if.sv
// MMU register bus plus the CPU request/vector/ack handshake.
interface interrupt_controller_if;
  logic [15:0] A_mmu;
  logic [7:0]  Di_mmu;
  logic [7:0]  Do_mmu;
  logic        wr_mmu;
  logic        rd_mmu;
  logic        cs_mmu;
  logic        irq_req;
  logic [7:0]  irq_vector;
  logic        irq_ack;
  logic        wake;

  modport master (
    output A_mmu, Di_mmu, wr_mmu, rd_mmu, cs_mmu, irq_ack,
    input  Do_mmu, irq_req, irq_vector, wake
  );

  modport slave (
    input  A_mmu, Di_mmu, wr_mmu, rd_mmu, cs_mmu, irq_ack,
    output Do_mmu, irq_req, irq_vector, wake
  );
endinterface

// File: rtl/interrupt_controller_priority_enc.sv
// Lowest-set-bit encoder over the 5 interrupt sources; bit 0 is highest
// priority. Shared with the CPU HALT logic.
module irq_priority_enc (
  input  logic [4:0] req,
  output logic [2:0] idx,
  output logic       valid
);
  always_comb begin
    idx   = 3'd0;
    valid = |req;
    // Scan downward so the lowest set bit is the last assignment.
    for (int i = 4; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end
endmodule

// File: rtl/interrupt_controller.sv
// IF/IE register block with rising-edge capture of the peripheral interrupt
// lines and a prioritised request/ack handshake to the CPU.
module interrupt_controller #(
  parameter int         NUM_SRC  = interrupt_controller_pkg::NUM_SRC,
  parameter logic [7:0] VEC_BASE = interrupt_controller_pkg::VEC_BASE
) (
  input  logic                         clock,
  input  logic                         reset,
  interrupt_controller_if.slave        bus,
  input  logic                         vblankIRQ,
  input  logic                         statIRQ,
  input  logic                         timerIRQ,
  input  logic                         serialIRQ,
  input  logic                         joypadIRQ
);
  import interrupt_controller_pkg::*;

  logic [NUM_SRC-1:0] src, prev_q, rise, if_q, if_d, pending;
  logic [7:0]         ie_q;
  logic [1:0]         state_q, state_d;
  logic [2:0]         idx;
  logic               valid;
  logic               wr_if, wr_ie, rd_en, ack_ok;

  assign src     = {joypadIRQ, serialIRQ, timerIRQ, statIRQ, vblankIRQ};
  assign rise    = src & ~prev_q;
  assign pending = if_q & ie_q[NUM_SRC-1:0];

  irq_priority_enc u_enc (
    .req   (pending),
    .idx   (idx),
    .valid (valid)
  );

  assign wr_if  = bus.cs_mmu && bus.wr_mmu && (bus.A_mmu == IF_ADDR);
  assign wr_ie  = bus.cs_mmu && bus.wr_mmu && (bus.A_mmu == IE_ADDR);
  assign rd_en  = bus.cs_mmu && bus.rd_mmu;
  assign ack_ok = bus.irq_ack && (state_q == REQ) && valid;

  // Write, then ack-clear, then set: a fresh edge always survives.
  always_comb begin
    if_d = wr_if ? bus.Di_mmu[NUM_SRC-1:0] : if_q;
    if (ack_ok) if_d = if_d & ~(NUM_SRC'(1) << idx);
    if_d = if_d | rise;
  end

  always_comb begin
    bus.Do_mmu = 8'h00;
    if (rd_en) begin
      if (bus.A_mmu == IF_ADDR)      bus.Do_mmu = {3'b111, if_q};
      else if (bus.A_mmu == IE_ADDR) bus.Do_mmu = ie_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = REQ;
      REQ:     if (ack_ok) state_d = HOLD;
               else if (!valid) state_d = IDLE;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_q    <= '0;
      ie_q    <= 8'h00;
      prev_q  <= '0;
      state_q <= IDLE;
    end else begin
      if_q    <= if_d;
      prev_q  <= src;
      state_q <= state_d;
      if (wr_ie) ie_q <= bus.Di_mmu;
    end
  end

  assign bus.irq_req    = (state_q == REQ);
  assign bus.irq_vector = (state_q == REQ) ? irq_vector_of(VEC_BASE, idx) : VEC_BASE;
  assign bus.wake       = |pending;
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Downstream consumer of the timer's timerIRQ and of the other peripheral interrupt lines (vblank, LCD STAT, serial, joypad).
- Holds the IF (0xFF0F) and IE (0xFFFF) registers on the MMU bus and edge-detects each source into IF.
- Drives a prioritised request/vector/acknowledge handshake to the CPU core, plus a HALT wake line.
- The IME flag is not held here; it stays in the CPU.

Parameters:
- NUM_SRC, 5, number of interrupt sources. Fixed at 5; any other value is unsupported.
- VEC_BASE, 8'h40, vector of source 0. Source n vector = VEC_BASE + 8*n.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- A_mmu  in  16  MMU address
- Di_mmu  in  8  MMU write data
- Do_mmu  out  8  MMU read data. Combinational; 0 when not selected.
- wr_mmu  in  1  write strobe
- rd_mmu  in  1  read strobe
- cs_mmu  in  1  chip select
- vblankIRQ  in  1  level source, bit 0
- statIRQ  in  1  level source, bit 1
- timerIRQ  in  1  level source, bit 2
- serialIRQ  in  1  level source, bit 3
- joypadIRQ  in  1  level source, bit 4
- irq_req  out  1  interrupt request to CPU
- irq_vector  out  8  vector for the request
- irq_ack  in  1  CPU accepts the current request (1-cycle pulse)
- wake  out  1  (IF & IE & 5'h1F) != 0. Combinational; ignores IME.

Behaviour:
Reset (async, active-high):
- IF=0, IE=0, edge history=0, state=IDLE.
- irq_req=0, irq_vector=VEC_BASE.
- Do_mmu follows the combinational read rule.

Register reads (cs_mmu && rd_mmu; otherwise Do_mmu=0):
- FF0F returns {3'b111, IF[4:0]}.
- FFFF returns IE[7:0]; all 8 bits are stored.
- Any other address returns 0.

Register writes (cs_mmu && wr_mmu, on the clock edge):
- FF0F: IF <= Di_mmu[4:0].
- FFFF: IE <= Di_mmu.

Edge detection:
- prev[n] <= src[n] every cycle.
- rise[n] = src[n] & ~prev[n].
- A source held high sets IF exactly once; it must drop before it can set IF again.

Next-IF priority, applied in this order each cycle:
1. Base value: the bus write value if FF0F is written, else the current IF.
2. Clear the acknowledged bit if an ack is accepted this cycle.
3. OR in rise[4:0]. A set always wins over a write-clear or ack-clear of the same bit in the same cycle.

pending = IF & IE[4:0]. Priority: bit 0 highest, bit 4 lowest.

FSM:
- IDLE: irq_req=0. If pending != 0, go to REQ.
- REQ:
  - irq_req=1.
  - irq_vector = VEC_BASE + 8*(index of the lowest set pending bit), re-evaluated every cycle, so a higher-priority arrival pre-empts before ack.
  - If pending becomes 0 before ack (software cleared IF/IE), go to IDLE and irq_req drops the next cycle.
  - On irq_ack: clear IF bit for the vector presented that cycle, go to HOLD.
- HOLD: irq_req=0 for exactly one cycle (prevents double dispatch while the CPU sees the cleared IF), then go to IDLE.
- irq_ack outside REQ is ignored: no IF change.

Timing:
- Latency from a source rising edge (sampled at clock edge k) to irq_req=1 is 2 clocks: IF set at k, REQ at k+1, irq_req visible after k+1.
- The REQ state, and therefore irq_req, is registered. irq_vector is combinational from IF/IE while in REQ.
- Reset asserted mid-handshake: immediate return to IDLE, IF cleared, no pending ack remembered.

Decomposition:
- Shared package/header holds:
  - IF_ADDR=16'hFF0F, IE_ADDR=16'hFFFF.
  - Source bit indices IRQ_VBLANK=0 … IRQ_JOYPAD=4.
  - VEC_BASE.
  - FSM state encodings IDLE/REQ/HOLD.
- One natural sub-module: irq_priority_enc. Combinational 5-bit lowest-set-bit encoder producing a 3-bit index and a valid flag. Reused by the CPU HALT logic.

Test Plan:
- Reset, then read FF0F / FFFF -> 8'hE0 / 8'h00; irq_req=0, wake=0.
- IE=8'h04, pulse timerIRQ high for 10 cycles -> IF=5'h04 exactly once, irq_req=1 two clocks after the edge, vector=8'h50; ack -> IF=0, irq_req low for the HOLD cycle and thereafter.
- IE=8'h1F, raise timerIRQ and joypadIRQ together -> vector 8'h50; ack -> IF=5'h10; after HOLD, irq_req=1 with vector 8'h60.
- In REQ with vector 8'h50, raise vblankIRQ -> vector switches to 8'h40 next cycle; ack clears only bit 0, IF=5'h04 remains.
- Write FF0F=8'h00 in the same cycle as a serialIRQ rising edge -> IF=5'h08. IE=0 with IF=5'h08 -> wake=0, irq_req=0.
- Assert reset while in REQ -> irq_req=0 and IF=0 immediately; a later ack pulse has no effect.
